dr_out: RTL and testbench
=========================

// Module: dr_out
// PURPOSE
//  Store-side serializer for the byte-wide data memory; the write-direction counterpart of the load-side byte assembler.
//  Takes a 32-bit store word plus byte address from the CPU datapath (SW/SH/SB).
//  Emits it as 1, 2 or 4 little-endian byte writes, one per cycle, to the 8-bit memory port.
//  Holds busy so the pipeline stalls until the last byte is written.
// PARAMETERS
//  ADDR_W   32   width of byte address in/out
// PORTS
//  clk       in   1       system clock, all state on posedge
//  rst       in   1       asynchronous, active-low reset (asserted when 0)
//  start     in   1       1-cycle request; sampled only while busy=0
//  num       in   3       store type: 3'b000 SW (4 B), 3'b001 SH (2 B), 3'b011 SB (1 B); other codes invalid
//  addr      in   ADDR_W  byte address of lowest byte
//  in_data   in   32      store word; SH uses [15:0], SB uses [7:0]
//  mem_wait  in   1       memory stall; 1 = hold current byte
//  busy      out  1       transfer in progress
//  we        out  1       byte write enable to memory
//  out_addr  out  ADDR_W  byte address of current write
//  out_data  out  8       byte being written
//  done      out  1       1-cycle pulse after the last byte is accepted
//  err       out  1       1-cycle pulse, alignment fault (only with DR_OUT_ALIGN_CHK_EN)
// BEHAVIOUR
//  - Reset: while rst=0, all outputs and internal regs are 0 asynchronously (busy, we, done, err, out_addr, out_data, count).
//  - rst low mid-transfer abandons the transfer; no further bytes are written after release.
//  - All outputs are registered.
//  - States: IDLE (busy=0), XFER (busy=1). done is a flag, not a state.
//  - IDLE:
//    - Edge with start=1 and valid num: latch in_data, addr, last.
//    - last = 3 for SW, 1 for SH, 0 for SB.
//    - Same edge: count=0, busy=1, we=1, out_addr=addr, out_data=in_data[7:0]. Enter XFER.
//  - IDLE, start=1 with invalid num: ignored. Stay IDLE, no we, no done.
//  - XFER, edge with mem_wait=1: hold count, we, out_addr and out_data.
//  - XFER, edge with mem_wait=0 and count!=last:
//    - count+1.
//    - out_data = byte[count+1] of latched word; out_addr = latched addr + count+1.
//  - XFER, edge with mem_wait=0 and count==last: we=0, busy=0, done=1 for one cycle. Enter IDLE.
//  - Latency with mem_wait=0:
//    - SW: we high 4 cycles, done in 5th cycle after start edge.
//    - SH: 2 + done.
//    - SB: 1 + done.
//  - start while busy=1 is ignored; in_data/addr changes during XFER have no effect.
//  - Back-to-back: start asserted in the done cycle (busy=0) is accepted that edge.
//  - The new transfer's we follows done with no gap.
//  - Address arithmetic is ADDR_W-bit modulo: addr=all-ones, SH writes all-ones then 0.
// CONFIGURATION
//  - DR_OUT_ALIGN_CHK_EN defined: at accept, check alignment.
//    - SW needs addr[1:0]==0; SH needs addr[0]==0.
//    - On misalignment: no write, stay IDLE, err=1 for one cycle, no done.
//  - Undefined: no check; err tied 0; misaligned stores write bytes at addr..addr+last.
// TESTING
//  - SW: addr=0x10, in_data=0xA1B2C3D4, mem_wait=0
//    -> writes (0x10,D4)(0x11,C3)(0x12,B2)(0x13,A1) on 4 consecutive cycles, then done=1.
//  - SH: addr=0x22, in_data=0xFFFF5A6B -> (0x22,6B)(0x23,5A), 2 writes only, then done.
//  - SB: in_data=0x000000EE, mem_wait=1 for 3 cycles
//    -> we/out_data=EE held 4 cycles, then done; busy high 4 cycles.
//  - SW start, rst=0 after 2nd byte -> busy/we=0 immediately; no 3rd byte after release.
//  - start with num=3'b100 -> no we, busy stays 0. start while busy -> ignored.
//  - Back-to-back SB, then SB.
//  - Alignment, DR_OUT_ALIGN_CHK_EN defined: SW addr=0x11 -> err pulse, no writes.
//  - Alignment, undefined: SW addr=0x11 writes 0x11..0x14.

Source files
------------

// File: rtl/dr_out.sv
// Store-side byte serializer: splits an SW/SH/SB store into 1, 2 or 4 little-endian byte writes.
// Optional alignment check enabled by defining DR_OUT_ALIGN_CHK_EN.
module dr_out #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        num,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       in_data,
  input  logic              mem_wait,
  output logic              busy,
  output logic              we,
  output logic [ADDR_W-1:0] out_addr,
  output logic [7:0]        out_data,
  output logic              done,
  output logic              err
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] XFER = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [1:0]        count_q, count_d;
  logic [1:0]        last_q, last_d;
  logic [31:0]       data_q, data_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [7:0]        out_data_q, out_data_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic       num_valid;
  logic [1:0] last_sel;
  logic       misaligned;
  logic [1:0] nxt;

  always_comb begin
    num_valid = 1'b1;
    last_sel  = 2'd0;
    case (num)
      3'b000:  last_sel = 2'd3;
      3'b001:  last_sel = 2'd1;
      3'b011:  last_sel = 2'd0;
      default: num_valid = 1'b0;
    endcase
  end

`ifdef DR_OUT_ALIGN_CHK_EN
  always_comb begin
    misaligned = ((num == 3'b000) && (addr[1:0] != 2'b00)) ||
                 ((num == 3'b001) && addr[0]);
  end
`else
  assign misaligned = 1'b0;
`endif

  assign nxt = count_q + 2'd1;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    last_d     = last_q;
    data_d     = data_q;
    base_d     = base_q;
    we_d       = we_q;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && num_valid) begin
          if (misaligned) begin
            err_d = 1'b1;
          end else begin
            // First byte goes out on the accepting edge itself.
            state_d    = XFER;
            data_d     = in_data;
            base_d     = addr;
            last_d     = last_sel;
            count_d    = 2'd0;
            we_d       = 1'b1;
            out_addr_d = addr;
            out_data_d = in_data[7:0];
          end
        end
      end
      default: begin
        if (!mem_wait) begin
          if (count_q == last_q) begin
            state_d = IDLE;
            we_d    = 1'b0;
            done_d  = 1'b1;
          end else begin
            count_d    = nxt;
            out_addr_d = base_q + ADDR_W'(nxt);
            out_data_d = data_q[{nxt, 3'b000} +: 8];
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      count_q    <= 2'd0;
      last_q     <= 2'd0;
      data_q     <= 32'd0;
      base_q     <= '0;
      we_q       <= 1'b0;
      out_addr_q <= '0;
      out_data_q <= 8'd0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      last_q     <= last_d;
      data_q     <= data_d;
      base_q     <= base_d;
      we_q       <= we_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign busy     = state_q;
  assign we       = we_q;
  assign out_addr = out_addr_q;
  assign out_data = out_data_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_dr_out.sv
// Directed bench for dr_out: table of plain stores plus hand-written multi-cycle sequences.
module tb_dr_out;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  num = 3'b000;
  logic [31:0] addr = 32'd0;
  logic [31:0] in_data = 32'd0;
  logic        mem_wait = 1'b0;
  logic        busy, we, done, err;
  logic [31:0] out_addr;
  logic [7:0]  out_data;

  int checks = 0;
  int errors = 0;

  dr_out #(.ADDR_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .num      (num),
    .addr     (addr),
    .in_data  (in_data),
    .mem_wait (mem_wait),
    .busy     (busy),
    .we       (we),
    .out_addr (out_addr),
    .out_data (out_data),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]        num;
    logic [31:0]       addr;
    logic [31:0]       data;
    int                n;
    logic [3:0][31:0]  ea;
    logic [3:0][7:0]   ed;
  } vec_t;

  vec_t tbl [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input logic [2:0] n, input logic [31:0] a, input logic [31:0] d);
    start   = 1'b1;
    num     = n;
    addr    = a;
    in_data = d;
    tick();
    start   = 1'b0;
  endtask

  task automatic chk_byte(input string name, input logic [31:0] ea, input logic [7:0] ed);
    chk({name, ".we"}, {31'd0, we}, 32'd1);
    chk({name, ".busy"}, {31'd0, busy}, 32'd1);
    chk({name, ".addr"}, out_addr, ea);
    chk({name, ".data"}, {24'd0, out_data}, {24'd0, ed});
  endtask

  task automatic chk_done(input string name);
    chk({name, ".done"}, {31'd0, done}, 32'd1);
    chk({name, ".we_off"}, {31'd0, we}, 32'd0);
    chk({name, ".idle"}, {31'd0, busy}, 32'd0);
    chk({name, ".err"}, {31'd0, err}, 32'd0);
  endtask

  initial begin
    tbl[0] = '{3'b000, 32'h10, 32'hA1B2C3D4, 4,
               {32'h13, 32'h12, 32'h11, 32'h10}, {8'hA1, 8'hB2, 8'hC3, 8'hD4}};
    tbl[1] = '{3'b001, 32'h22, 32'hFFFF5A6B, 2,
               {32'h0, 32'h0, 32'h23, 32'h22}, {8'h00, 8'h00, 8'h5A, 8'h6B}};
    tbl[2] = '{3'b011, 32'h35, 32'hCAFE0077, 1,
               {32'h0, 32'h0, 32'h0, 32'h35}, {8'h00, 8'h00, 8'h00, 8'h77}};
    tbl[3] = '{3'b000, 32'h100, 32'h01020304, 4,
               {32'h103, 32'h102, 32'h101, 32'h100}, {8'h01, 8'h02, 8'h03, 8'h04}};

    // Reset state
    #12;
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.we", {31'd0, we}, 32'd0);
    chk("rst.done", {31'd0, done}, 32'd0);
    chk("rst.err", {31'd0, err}, 32'd0);
    chk("rst.addr", out_addr, 32'd0);
    chk("rst.data", {24'd0, out_data}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Table-driven plain stores; inputs scrambled after accept must not matter.
    for (int i = 0; i < 4; i++) begin
      start_req(tbl[i].num, tbl[i].addr, tbl[i].data);
      addr    = 32'hDEAD0000;
      in_data = 32'h99999999;
      for (int b = 0; b < tbl[i].n; b++) begin
        chk_byte($sformatf("vec%0d.b%0d", i, b), tbl[i].ea[b], tbl[i].ed[b]);
        if (b < tbl[i].n - 1) tick();
      end
      tick();
      chk_done($sformatf("vec%0d", i));
      tick();
      chk($sformatf("vec%0d.done_pulse", i), {31'd0, done}, 32'd0);
    end

    // SB with mem_wait held for 3 edges: byte held 4 cycles.
    start_req(3'b011, 32'h44, 32'h000000EE);
    mem_wait = 1'b1;
    chk_byte("wait.c0", 32'h44, 8'hEE);
    for (int c = 1; c < 4; c++) begin
      tick();
      chk_byte($sformatf("wait.c%0d", c), 32'h44, 8'hEE);
      chk($sformatf("wait.nodone%0d", c), {31'd0, done}, 32'd0);
    end
    mem_wait = 1'b0;
    tick();
    chk_done("wait");
    tick();

    // Reset mid-transfer abandons the store.
    start_req(3'b000, 32'h40, 32'h11223344);
    chk_byte("mrst.b0", 32'h40, 8'h44);
    tick();
    chk_byte("mrst.b1", 32'h41, 8'h33);
    rst = 1'b0;
    #1;
    chk("mrst.busy", {31'd0, busy}, 32'd0);
    chk("mrst.we", {31'd0, we}, 32'd0);
    chk("mrst.addr", out_addr, 32'd0);
    chk("mrst.data", {24'd0, out_data}, 32'd0);
    #2;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("mrst.post_we%0d", c), {31'd0, we}, 32'd0);
      chk($sformatf("mrst.post_done%0d", c), {31'd0, done}, 32'd0);
    end

    // Invalid store type is ignored.
    start_req(3'b100, 32'h70, 32'h12345678);
    chk("inv.we", {31'd0, we}, 32'd0);
    chk("inv.busy", {31'd0, busy}, 32'd0);
    tick();
    chk("inv.done", {31'd0, done}, 32'd0);

    // start held high during a transfer is ignored.
    start_req(3'b000, 32'h50, 32'h55667788);
    start   = 1'b1;
    num     = 3'b011;
    addr    = 32'h90;
    in_data = 32'h000000CC;
    chk_byte("sbusy.b0", 32'h50, 8'h88);
    tick();
    chk_byte("sbusy.b1", 32'h51, 8'h77);
    tick();
    chk_byte("sbusy.b2", 32'h52, 8'h66);
    tick();
    chk_byte("sbusy.b3", 32'h53, 8'h55);
    tick();
    chk_done("sbusy");
    start = 1'b0;
    tick();

    // Back-to-back SB: second start in the done cycle.
    start_req(3'b011, 32'h60, 32'h000000AA);
    chk_byte("b2b.first", 32'h60, 8'hAA);
    tick();
    chk_done("b2b.first");
    start_req(3'b011, 32'h61, 32'h000000BB);
    chk_byte("b2b.second", 32'h61, 8'hBB);
    chk("b2b.done_clr", {31'd0, done}, 32'd0);
    tick();
    chk_done("b2b.second");
    tick();

    // Misaligned SW at 0x11 and SH at all-ones (wrap).
`ifdef DR_OUT_ALIGN_CHK_EN
    start_req(3'b000, 32'h11, 32'hDEADBEEF);
    chk("align.err", {31'd0, err}, 32'd1);
    chk("align.we", {31'd0, we}, 32'd0);
    chk("align.busy", {31'd0, busy}, 32'd0);
    tick();
    chk("align.err_pulse", {31'd0, err}, 32'd0);
    chk("align.done", {31'd0, done}, 32'd0);
    start_req(3'b001, 32'hFFFFFFFF, 32'h00001234);
    chk("wrap.err", {31'd0, err}, 32'd1);
    chk("wrap.we", {31'd0, we}, 32'd0);
    tick();
`else
    start_req(3'b000, 32'h11, 32'hDEADBEEF);
    chk("align.err", {31'd0, err}, 32'd0);
    chk_byte("align.b0", 32'h11, 8'hEF);
    tick();
    chk_byte("align.b1", 32'h12, 8'hBE);
    tick();
    chk_byte("align.b2", 32'h13, 8'hAD);
    tick();
    chk_byte("align.b3", 32'h14, 8'hDE);
    tick();
    chk_done("align");
    tick();
    start_req(3'b001, 32'hFFFFFFFF, 32'h00001234);
    chk_byte("wrap.b0", 32'hFFFFFFFF, 8'h34);
    tick();
    chk_byte("wrap.b1", 32'h00000000, 8'h12);
    tick();
    chk_done("wrap");
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
